// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency single-ported memory between IF and MEM stages.
// Revision: 1.0 - initial release
`default_nettype none

module mem_port_arbiter #(
  parameter int LATENCY = 1,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ready,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wmask,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ready,
  output logic                IStall,
  output logic                MemStall,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_last_d;
  logic             w_last_d_nxt;
  logic             w_req_i;
  logic             w_req_d;
  logic             w_grant_d;

  assign w_req_i = i_req;
  assign w_req_d = d_read | d_write;
  // On a tie the port that did not win last time goes first.
  assign w_grant_d = w_req_d & (~w_req_i | ~r_last_d);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_last_d <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_last_d <= w_last_d_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_last_d_nxt = r_last_d;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_wmask    = '0;
    i_ready      = 1'b0;
    d_ready      = 1'b0;
    i_rdata      = '0;
    d_rdata      = '0;
    case (r_state)
      ST_IDLE: begin
        // Reset forces IDLE, so only the grant path needs explicit gating.
        if (!reset && (w_req_i || w_req_d)) begin
          mem_en    = 1'b1;
          w_cnt_nxt = C_CNT_LOAD;
          if (w_grant_d) begin
            mem_we       = d_write;
            mem_addr     = d_addr;
            mem_wdata    = d_wdata;
            mem_wmask    = d_wmask;
            w_state_nxt  = ST_BUSY_D;
            w_last_d_nxt = 1'b1;
          end else begin
            mem_addr     = i_addr;
            w_state_nxt  = ST_BUSY_I;
            w_last_d_nxt = 1'b0;
          end
        end
      end
      ST_BUSY_I: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          i_ready     = 1'b1;
          i_rdata     = mem_rdata;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY_D: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          d_ready     = 1'b1;
          d_rdata     = mem_rdata;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign IStall   = i_req & ~i_ready & ~reset;
  assign MemStall = w_req_d & ~d_ready & ~reset;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic against a transaction-level model,
// on three instances with LATENCY 1, 3 and 4.
`default_nettype none

module tb_mem_port_arbiter;

  localparam int N = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic        t_ireq   [N];
  logic [31:0] t_iaddr  [N];
  logic        t_drd    [N];
  logic        t_dwr    [N];
  logic [31:0] t_daddr  [N];
  logic [31:0] t_dwdata [N];
  logic [3:0]  t_dwmask [N];
  logic [31:0] mem_rdata;

  logic [31:0] i_rdata   [N];
  logic [31:0] d_rdata   [N];
  logic [31:0] mem_addr  [N];
  logic [31:0] mem_wdata [N];
  logic [3:0]  mem_wmask [N];
  logic        i_ready   [N];
  logic        d_ready   [N];
  logic        istall    [N];
  logic        mstall    [N];
  logic        mem_en    [N];
  logic        mem_we    [N];

  int vec = 0;
  int err = 0;
  int lat [N] = '{1, 3, 4};

  // transaction-level model state per instance
  bit mb [N];
  bit mport [N];
  bit mwr [N];
  bit mlast [N];
  int mg [N];
  bit ps_i [N];
  bit ps_d [N];
  int cyc;

  always #5 clk = ~clk;

  genvar k;
  generate
    for (k = 0; k < N; k++) begin : g_dut
      mem_port_arbiter #(
        .LATENCY((k == 0) ? 1 : (k == 1) ? 3 : 4),
        .ADDR_W (32),
        .DATA_W (32)
      ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .i_req    (t_ireq[k]),
        .i_addr   (t_iaddr[k]),
        .i_rdata  (i_rdata[k]),
        .i_ready  (i_ready[k]),
        .d_read   (t_drd[k]),
        .d_write  (t_dwr[k]),
        .d_addr   (t_daddr[k]),
        .d_wdata  (t_dwdata[k]),
        .d_wmask  (t_dwmask[k]),
        .d_rdata  (d_rdata[k]),
        .d_ready  (d_ready[k]),
        .IStall   (istall[k]),
        .MemStall (mstall[k]),
        .mem_en   (mem_en[k]),
        .mem_we   (mem_we[k]),
        .mem_addr (mem_addr[k]),
        .mem_wdata(mem_wdata[k]),
        .mem_wmask(mem_wmask[k]),
        .mem_rdata(mem_rdata)
      );
    end
  endgenerate

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < N; i++) begin
      t_ireq[i] = 1'b0; t_iaddr[i] = '0; t_drd[i] = 1'b0; t_dwr[i] = 1'b0;
      t_daddr[i] = '0; t_dwdata[i] = '0; t_dwmask[i] = '0;
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    step();
    #2;
    t_ireq[0] = 1'b1; t_iaddr[0] = 32'h10;
    t_drd[1] = 1'b1;  t_daddr[1] = 32'h20;
    t_dwr[2] = 1'b1;  t_daddr[2] = 32'h30; t_dwmask[2] = 4'hF;
    mem_rdata = $urandom;
    reset = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      vec++;
      if ({mem_en[i], istall[i], mstall[i], i_ready[i], d_ready[i]} !== 5'b0) begin
        err++;
        $display("FAIL reset_ctrl dut%0d: en/is/ms/ir/dr=%b, required 00000", i,
                 {mem_en[i], istall[i], mstall[i], i_ready[i], d_ready[i]});
      end
      vec++;
      if ({i_rdata[i], d_rdata[i], mem_addr[i]} !== 96'h0) begin
        err++;
        $display("FAIL reset_data dut%0d: irdata=%h drdata=%h addr=%h, required all 0", i,
                 i_rdata[i], d_rdata[i], mem_addr[i]);
      end
    end
    idle_inputs();
    step();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      for (int i = 0; i < N; i++) begin
        vec++;
        if ({mem_en[i], istall[i], mstall[i]} !== 3'b000) begin
          err++;
          $display("FAIL post_reset_idle dut%0d c%0d: en/is/ms=%b, required 000", i, c,
                   {mem_en[i], istall[i], mstall[i]});
        end
      end
    end
  endtask

  task automatic test_single_load();
    do_reset();
    step();
    t_drd[0] = 1'b1; t_daddr[0] = 32'h100; mem_rdata = $urandom;
    #1;
    vec++;
    if ({mstall[0], mem_en[0], mem_we[0], mem_addr[0]} !== {3'b110, 32'h100}) begin
      err++;
      $display("FAIL load_grant: ms/en/we=%b addr=%h, required 110 addr=00000100",
               {mstall[0], mem_en[0], mem_we[0]}, mem_addr[0]);
    end
    step();
    mem_rdata = 32'hDEADBEEF;
    #1;
    vec++;
    if ({d_ready[0], mstall[0], mem_en[0], d_rdata[0]} !== {3'b100, 32'hDEADBEEF}) begin
      err++;
      $display("FAIL load_done: dr/ms/en=%b drdata=%h, required 100 drdata=deadbeef",
               {d_ready[0], mstall[0], mem_en[0]}, d_rdata[0]);
    end
    step();
    t_drd[0] = 1'b0;
    #1;
    vec++;
    if ({mem_en[0], d_ready[0], d_rdata[0]} !== 34'h0) begin
      err++;
      $display("FAIL load_after: en/dr=%b drdata=%h, required 00 drdata=0",
               {mem_en[0], d_ready[0]}, d_rdata[0]);
    end
  endtask

  task automatic test_store();
    logic [72:0] act;
    logic [72:0] req;
    do_reset();
    step();
    t_dwr[1] = 1'b1; t_daddr[1] = 32'h40; t_dwdata[1] = 32'h12345678; t_dwmask[1] = 4'hF;
    mem_rdata = $urandom;
    #1;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin
        step();
        mem_rdata = $urandom;
        #1;
      end
      act = {mem_en[1], mem_we[1] & mem_en[1], mem_wmask[1], mem_wdata[1], mem_addr[1],
             mstall[1], d_ready[1]};
      if (c == 0)      req = {1'b1, 1'b1, 4'hF, 32'h12345678, 32'h40, 1'b1, 1'b0};
      else if (c < 3)  req = {1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0};
      else             req = {1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1};
      vec++;
      if (act !== req) begin
        err++;
        $display("FAIL store_c%0d: got %h, required %h", c, act, req);
      end
    end
    step();
    t_dwr[1] = 1'b0;
  endtask

  task automatic test_contention();
    do_reset();
    step();
    t_ireq[0] = 1'b1; t_iaddr[0] = 32'h200; t_drd[0] = 1'b1; t_daddr[0] = 32'h300;
    mem_rdata = $urandom;
    #1;
    vec++;
    if ({mem_en[0], mem_addr[0], istall[0], mstall[0]} !== {1'b1, 32'h300, 2'b11}) begin
      err++;
      $display("FAIL tie1_d_wins: en=%b addr=%h is/ms=%b, required en=1 addr=300 11",
               mem_en[0], mem_addr[0], {istall[0], mstall[0]});
    end
    step();
    mem_rdata = $urandom;
    #1;
    vec++;
    if ({d_ready[0], i_ready[0], mem_en[0], istall[0], mstall[0], d_rdata[0]} !==
        {5'b10010, mem_rdata}) begin
      err++;
      $display("FAIL tie1_d_done: dr/ir/en/is/ms=%b drdata=%h, required 10010 drdata=%h",
               {d_ready[0], i_ready[0], mem_en[0], istall[0], mstall[0]}, d_rdata[0], mem_rdata);
    end
    step();
    t_drd[0] = 1'b0;
    #1;
    vec++;
    if ({mem_en[0], mem_we[0], mem_wmask[0], istall[0], mem_addr[0]} !== {7'b1000001, 32'h200}) begin
      err++;
      $display("FAIL tie1_i_grant: en/we/mask/is=%b addr=%h, required 1000001 addr=200",
               {mem_en[0], mem_we[0], mem_wmask[0], istall[0]}, mem_addr[0]);
    end
    step();
    mem_rdata = $urandom;
    #1;
    vec++;
    if ({i_ready[0], istall[0], i_rdata[0], d_rdata[0]} !== {2'b10, mem_rdata, 32'h0}) begin
      err++;
      $display("FAIL tie1_i_done: ir/is=%b irdata=%h drdata=%h, required 10 irdata=%h drdata=0",
               {i_ready[0], istall[0]}, i_rdata[0], d_rdata[0], mem_rdata);
    end
    // last winner was I, so the next tie goes to D
    step();
    t_iaddr[0] = 32'h204; t_drd[0] = 1'b1; t_daddr[0] = 32'h304;
    #1;
    vec++;
    if ({mem_en[0], mem_addr[0]} !== {1'b1, 32'h304}) begin
      err++;
      $display("FAIL tie2_d_wins: en=%b addr=%h, required en=1 addr=304", mem_en[0], mem_addr[0]);
    end
    step();
    step();
    t_drd[0] = 1'b0;
    step();
    // D-only access leaves last winner = D, so the following tie goes to I
    step();
    t_ireq[0] = 1'b0; t_drd[0] = 1'b1; t_daddr[0] = 32'h308;
    step();
    step();
    t_ireq[0] = 1'b1; t_iaddr[0] = 32'h208; t_daddr[0] = 32'h30C;
    #1;
    vec++;
    if ({mem_en[0], mem_addr[0], mstall[0]} !== {1'b1, 32'h208, 1'b1}) begin
      err++;
      $display("FAIL tie3_i_wins: en=%b addr=%h ms=%b, required en=1 addr=208 ms=1",
               mem_en[0], mem_addr[0], mstall[0]);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_fetch();
    logic [31:0] pc;
    do_reset();
    pc = 32'h1000;
    for (int n = 0; n < 12; n++) begin
      step();
      t_ireq[0] = 1'b1; t_iaddr[0] = pc; mem_rdata = $urandom;
      #1;
      vec++;
      if (n % 2 == 0) begin
        if ({mem_en[0], istall[0], i_ready[0], mem_addr[0]} !== {3'b110, pc}) begin
          err++;
          $display("FAIL fetch_grant n%0d: en/is/ir=%b addr=%h, required 110 addr=%h", n,
                   {mem_en[0], istall[0], i_ready[0]}, mem_addr[0], pc);
        end
      end else begin
        if ({mem_en[0], istall[0], i_ready[0], i_rdata[0]} !== {3'b001, mem_rdata}) begin
          err++;
          $display("FAIL fetch_done n%0d: en/is/ir=%b irdata=%h, required 001 irdata=%h", n,
                   {mem_en[0], istall[0], i_ready[0]}, i_rdata[0], mem_rdata);
        end
        pc = pc + 32'd4;
      end
    end
    step();
    idle_inputs();
  endtask

  task automatic test_reset_busy();
    do_reset();
    step();
    t_drd[2] = 1'b1; t_daddr[2] = 32'h80;
    #1;
    vec++;
    if ({mem_en[2], mem_addr[2]} !== {1'b1, 32'h80}) begin
      err++;
      $display("FAIL rbusy_grant: en=%b addr=%h, required en=1 addr=80", mem_en[2], mem_addr[2]);
    end
    step();
    step();
    reset = 1'b1;
    #1;
    vec++;
    if ({mem_en[2], mstall[2], d_ready[2]} !== 3'b000) begin
      err++;
      $display("FAIL rbusy_in_reset: en/ms/dr=%b, required 000", {mem_en[2], mstall[2], d_ready[2]});
    end
    t_drd[2] = 1'b0;
    step();
    reset = 1'b0;
    #1;
    vec++;
    if ({mem_en[2], mstall[2], d_ready[2]} !== 3'b000) begin
      err++;
      $display("FAIL rbusy_release: en/ms/dr=%b, required 000", {mem_en[2], mstall[2], d_ready[2]});
    end
    step();
    mem_rdata = $urandom;
    #1;
    vec++;
    if ({mem_en[2], d_ready[2], d_rdata[2]} !== 34'h0) begin
      err++;
      $display("FAIL rbusy_no_ready: en/dr=%b drdata=%h, required 00 drdata=0",
               {mem_en[2], d_ready[2]}, d_rdata[2]);
    end
    step();
    t_drd[2] = 1'b1; t_daddr[2] = 32'h84;
    #1;
    vec++;
    if ({mem_en[2], mstall[2], mem_addr[2]} !== {2'b11, 32'h84}) begin
      err++;
      $display("FAIL rbusy_regrant: en/ms=%b addr=%h, required 11 addr=84",
               {mem_en[2], mstall[2]}, mem_addr[2]);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_random();
    bit          rq_i, rq_d, wd;
    bit          e_en, e_we, e_ir, e_dr, e_is, e_ms;
    logic [31:0] e_addr, e_wd, e_ird, e_drd;
    logic [3:0]  e_wm;
    logic [73:0] act, req;
    int          r;
    do_reset();
    cyc = 0;
    for (int i = 0; i < N; i++) begin
      mb[i] = 0; mlast[i] = 0; ps_i[i] = 0; ps_d[i] = 0; mport[i] = 0; mwr[i] = 0; mg[i] = 0;
    end
    for (int n = 0; n < 800; n++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (!ps_i[i]) begin
          t_ireq[i] = ($urandom_range(0, 9) < 6);
          t_iaddr[i] = $urandom & 32'h0000FFFC;
        end
        if (!ps_d[i]) begin
          r = $urandom_range(0, 9);
          t_drd[i] = (r < 3) || (r == 9);
          t_dwr[i] = (r >= 3 && r < 6) || (r == 9);
          t_daddr[i] = $urandom & 32'h0000FFFC;
          t_dwdata[i] = $urandom;
          t_dwmask[i] = 4'($urandom);
        end
      end
      mem_rdata = $urandom;
      #1;
      for (int i = 0; i < N; i++) begin
        rq_i = t_ireq[i];
        rq_d = t_drd[i] | t_dwr[i];
        e_en = 0; e_we = 0; e_ir = 0; e_dr = 0;
        e_addr = '0; e_wd = '0; e_wm = '0; e_ird = '0; e_drd = '0;
        if (!mb[i]) begin
          if (rq_i || rq_d) begin
            wd = rq_d && (!rq_i || !mlast[i]);
            e_en = 1;
            if (wd) begin
              e_we = t_dwr[i]; e_addr = t_daddr[i]; e_wd = t_dwdata[i]; e_wm = t_dwmask[i];
            end else begin
              e_addr = t_iaddr[i];
            end
            mb[i] = 1; mport[i] = wd; mwr[i] = wd && t_dwr[i]; mg[i] = cyc; mlast[i] = wd;
          end
        end else if (cyc == mg[i] + lat[i]) begin
          if (mport[i]) begin e_dr = 1; e_drd = mem_rdata; end
          else begin e_ir = 1; e_ird = mem_rdata; end
          mb[i] = 0;
        end
        e_is = rq_i && !e_ir;
        e_ms = rq_d && !e_dr;
        act = {mem_en[i], mem_we[i] & mem_en[i], mem_addr[i], mem_wdata[i], mem_wmask[i],
               i_ready[i], d_ready[i], istall[i], mstall[i]};
        req = {e_en, e_we, e_addr, e_wd, e_wm, e_ir, e_dr, e_is, e_ms};
        vec++;
        if (act !== req) begin
          err++;
          $display("FAIL rand_ctrl dut%0d cyc%0d: got %h, required %h", i, cyc, act, req);
        end
        vec++;
        if (i_rdata[i] !== e_ird) begin
          err++;
          $display("FAIL rand_irdata dut%0d cyc%0d: got %h, required %h", i, cyc, i_rdata[i], e_ird);
        end
        if (!(e_dr && mwr[i])) begin
          vec++;
          if (d_rdata[i] !== e_drd) begin
            err++;
            $display("FAIL rand_drdata dut%0d cyc%0d: got %h, required %h", i, cyc, d_rdata[i], e_drd);
          end
        end
        ps_i[i] = e_is;
        ps_d[i] = e_ms;
      end
      cyc++;
    end
    step();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    mem_rdata = '0;
    reset = 1'b1;
    test_reset();
    test_single_load();
    test_store();
    test_contention();
    test_fetch();
    test_reset_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
